nav_sequencer: RTL and testbench

Flight-control sequencer that drives the one-hot `mode` and `pos_mode` controls and the `jump_position` bus of the three-axis position datapath. It holds the commanded cruise speed and runs a safe jump sequence: request/acknowledge handshake, stop-and-charge delay, a one-cycle jump, and a cooldown. It also issues return-to-origin on request. It sits between the command module and the position datapath; all outputs are registered.

---
 rtl/nav_sequencer.sv | 136 +++++++++++++
 tb/tb_nav_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nav_sequencer.sv
// Jump/cruise sequencer for the three-axis position datapath.
// Owns the cruise speed, the jump handshake, charge and cooldown timing, and return-to-origin.
module nav_sequencer #(
   parameter int K               = 16,
   parameter int CHARGE_CYCLES   = 4,
   parameter int COOLDOWN_CYCLES = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [3:0]     cmd_mode,
   input  logic           home_req,
   input  logic           jump_req,
   input  logic [3*K-1:0] jump_target,
   output logic           jump_ack,
   output logic [3:0]     mode_out,
   output logic [3:0]     pos_mode_out,
   output logic [3*K-1:0] jump_position_out,
   output logic           busy,
   output logic           jump_done
);

   localparam int MAX_CYC = (CHARGE_CYCLES > COOLDOWN_CYCLES) ? CHARGE_CYCLES : COOLDOWN_CYCLES;
   localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CW-1:0] CHARGE_LOAD   = CW'(CHARGE_CYCLES - 1);
   localparam logic [CW-1:0] COOLDOWN_LOAD = CW'(COOLDOWN_CYCLES - 1);

   localparam logic [2:0] S_HOME     = 3'd0;
   localparam logic [2:0] S_CRUISE   = 3'd1;
   localparam logic [2:0] S_CHARGE   = 3'd2;
   localparam logic [2:0] S_JUMP     = 3'd3;
   localparam logic [2:0] S_COOLDOWN = 3'd4;

   localparam logic [3:0] MODE_STOP   = 4'b0001;
   localparam logic [3:0] POS_RESET   = 4'b0001;
   localparam logic [3:0] POS_SUBLITE = 4'b0010;
   localparam logic [3:0] POS_JUMP    = 4'b0100;

   logic [2:0]     state_reg, state_next;
   logic [CW-1:0]  count_reg, count_next;
   logic [3:0]     cruise_reg, cruise_next;
   logic [3*K-1:0] jump_pos_next;
   logic           ack_next, done_next, busy_next;
   logic [3:0]     mode_next, pos_mode_next;
   logic           cmd_onehot;

   assign cmd_onehot = (cmd_mode != 4'd0) && ((cmd_mode & (cmd_mode - 4'd1)) == 4'd0);

   always_comb begin
      state_next    = state_reg;
      count_next    = count_reg;
      cruise_next   = cmd_onehot ? cmd_mode : cruise_reg;
      jump_pos_next = jump_position_out;
      ack_next      = 1'b0;

      case (state_reg)
         S_HOME: begin
            state_next = S_CRUISE;
         end
         S_CRUISE: begin
            // Return-to-origin wins over a simultaneous jump request.
            if (home_req) begin
               state_next = S_HOME;
            end else if (jump_req) begin
               state_next    = S_CHARGE;
               count_next    = CHARGE_LOAD;
               jump_pos_next = jump_target;
               ack_next      = 1'b1;
            end
         end
         S_CHARGE: begin
            if (home_req) begin
               state_next = S_HOME;
               count_next = '0;
            end else if (count_reg == '0) begin
               state_next = S_JUMP;
            end else begin
               count_next = count_reg - 1'b1;
            end
         end
         S_JUMP: begin
            state_next = S_COOLDOWN;
            count_next = COOLDOWN_LOAD;
         end
         S_COOLDOWN: begin
            if (count_reg == '0) begin
               state_next = S_CRUISE;
            end else begin
               count_next = count_reg - 1'b1;
            end
         end
         default: begin
            state_next = S_HOME;
            count_next = '0;
         end
      endcase

      // Outputs are registered from the next state so they line up with the state they describe.
      pos_mode_next = POS_SUBLITE;
      mode_next     = MODE_STOP;
      if (state_next == S_HOME) begin
         pos_mode_next = POS_RESET;
      end else if (state_next == S_JUMP) begin
         pos_mode_next = POS_JUMP;
      end else if (state_next == S_CRUISE) begin
         mode_next = cruise_next;
      end
      done_next = (state_next == S_JUMP);
      busy_next = (state_next == S_CHARGE) || (state_next == S_JUMP) || (state_next == S_COOLDOWN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg         <= S_HOME;
         count_reg         <= '0;
         cruise_reg        <= MODE_STOP;
         jump_position_out <= '0;
         jump_ack          <= 1'b0;
         jump_done         <= 1'b0;
         busy              <= 1'b0;
         mode_out          <= MODE_STOP;
         pos_mode_out      <= POS_RESET;
      end else begin
         state_reg         <= state_next;
         count_reg         <= count_next;
         cruise_reg        <= cruise_next;
         jump_position_out <= jump_pos_next;
         jump_ack          <= ack_next;
         jump_done         <= done_next;
         busy              <= busy_next;
         mode_out          <= mode_next;
         pos_mode_out      <= pos_mode_next;
      end
   end

endmodule

// File: tb/tb_nav_sequencer.sv
// Bench for nav_sequencer: directed vector table, hand-written corner sequences,
// and randomized traffic against a cycle-count reference model.
module tb_nav_sequencer;

   localparam int K = 16;
   localparam int C = 4;
   localparam int D = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [3:0]     cmd_mode;
   logic           home_req;
   logic           jump_req;
   logic [3*K-1:0] jump_target;
   logic           jump_ack;
   logic [3:0]     mode_out;
   logic [3:0]     pos_mode_out;
   logic [3*K-1:0] jump_position_out;
   logic           busy;
   logic           jump_done;

   int tests  = 0;
   int failed = 0;

   nav_sequencer #(.K(K), .CHARGE_CYCLES(C), .COOLDOWN_CYCLES(D)) dut (
      .clk               (clk),
      .rst               (rst),
      .cmd_mode          (cmd_mode),
      .home_req          (home_req),
      .jump_req          (jump_req),
      .jump_target       (jump_target),
      .jump_ack          (jump_ack),
      .mode_out          (mode_out),
      .pos_mode_out      (pos_mode_out),
      .jump_position_out (jump_position_out),
      .busy              (busy),
      .jump_done         (jump_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  cmd;
      logic        home;
      logic        jump;
      logic [47:0] tgt;
      logic [3:0]  e_pm;
      logic [3:0]  e_mode;
      logic        e_ack;
      logic        e_done;
      logic        e_busy;
      logic [47:0] e_jp;
   } vec_t;

   vec_t tbl[$];

   task automatic add_vec(input logic [3:0] cmd, input logic home, input logic jump,
                          input logic [47:0] tgt, input logic [3:0] e_pm, input logic [3:0] e_mode,
                          input logic e_ack, input logic e_done, input logic e_busy,
                          input logic [47:0] e_jp);
      vec_t v;
      v.cmd = cmd; v.home = home; v.jump = jump; v.tgt = tgt;
      v.e_pm = e_pm; v.e_mode = e_mode; v.e_ack = e_ack; v.e_done = e_done;
      v.e_busy = e_busy; v.e_jp = e_jp;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pack_out();
      return {5'd0, jump_ack, jump_done, busy, pos_mode_out, mode_out, jump_position_out};
   endfunction

   // Reference model: a jump is tracked only as the number of cycles since it was accepted.
   logic        m_home;
   int          m_pos;
   logic [3:0]  m_cruise;
   logic [47:0] m_jp;
   logic        m_ack;

   task automatic model_reset();
      m_home = 1'b1; m_pos = 0; m_cruise = 4'b0001; m_jp = '0; m_ack = 1'b0;
   endtask

   task automatic model_step();
      m_ack = 1'b0;
      if (rst) begin
         model_reset();
      end else begin
         if ($countones(cmd_mode) == 1) m_cruise = cmd_mode;
         if (m_home) begin
            m_home = 1'b0;
         end else if (m_pos == 0) begin
            if (home_req) m_home = 1'b1;
            else if (jump_req) begin
               m_pos = 1; m_ack = 1'b1; m_jp = jump_target;
            end
         end else if (m_pos <= C) begin
            if (home_req) begin
               m_home = 1'b1; m_pos = 0;
            end else m_pos++;
         end else begin
            m_pos++;
            if (m_pos > C + D + 1) m_pos = 0;
         end
      end
   endtask

   function automatic logic [63:0] model_out();
      logic [3:0] pm, md;
      logic done, bsy;
      pm   = m_home ? 4'b0001 : (m_pos == C + 1) ? 4'b0100 : 4'b0010;
      md   = (m_home || m_pos != 0) ? 4'b0001 : m_cruise;
      done = (m_pos == C + 1);
      bsy  = (m_pos != 0);
      return {5'd0, m_ack, done, bsy, pm, md, m_jp};
   endfunction

   task automatic idle_inputs();
      home_req = 1'b0; jump_req = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [47:0] t249;
      logic        saw_jump;
      int          ack_idx[$];
      int          waited;
      t249 = {3{16'h0249}};

      rst = 1'b1; cmd_mode = 4'b0001; home_req = 1'b0; jump_req = 1'b0; jump_target = '0;

      // Vector table: inputs applied before an edge, outputs checked after it.
      add_vec(4'b0010, 0, 0, '0,   4'b0010, 4'b0010, 0, 0, 0, '0);
      add_vec(4'b0100, 0, 1, t249, 4'b0010, 4'b0001, 1, 0, 1, t249);
      for (int i = 0; i < C - 1; i++) add_vec(4'b0100, 0, 0, '0, 4'b0010, 4'b0001, 0, 0, 1, t249);
      add_vec(4'b0100, 0, 0, '0,   4'b0100, 4'b0001, 0, 1, 1, t249);
      for (int i = 0; i < D; i++) add_vec(4'b0100, 0, 0, '0, 4'b0010, 4'b0001, 0, 0, 1, t249);
      add_vec(4'b0100, 0, 0, '0,   4'b0010, 4'b0100, 0, 0, 0, t249);
      add_vec(4'b0110, 0, 0, '0,   4'b0010, 4'b0100, 0, 0, 0, t249);
      add_vec(4'b0110, 1, 1, '1,   4'b0001, 4'b0001, 0, 0, 0, t249);
      add_vec(4'b0110, 1, 0, '0,   4'b0010, 4'b0100, 0, 0, 0, t249);
      add_vec(4'b1000, 0, 0, '0,   4'b0010, 4'b1000, 0, 0, 0, t249);
      add_vec(4'b0000, 0, 0, '0,   4'b0010, 4'b1000, 0, 0, 0, t249);

      // Reset values while rst is held.
      @(negedge clk);
      @(negedge clk);
      check("reset_outputs", pack_out(), {5'd0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001, 48'd0});
      rst = 1'b0;
      #1 check("home_after_release", {60'd0, pos_mode_out}, 64'h1);

      foreach (tbl[i]) begin
         cmd_mode = tbl[i].cmd; home_req = tbl[i].home; jump_req = tbl[i].jump;
         jump_target = tbl[i].tgt;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("vec%0d", i), pack_out(),
               {5'd0, tbl[i].e_ack, tbl[i].e_done, tbl[i].e_busy, tbl[i].e_pm,
                tbl[i].e_mode, tbl[i].e_jp});
         $display("[TB] vec %0d pm=%b mode=%b ack=%b done=%b busy=%b", i, pos_mode_out,
                  mode_out, jump_ack, jump_done, busy);
      end

      // Abort in the second CHARGE cycle: no jump afterwards.
      idle_inputs(); cmd_mode = 4'b0010;
      do_reset();
      jump_req = 1'b1; jump_target = 48'h1111_2222_3333;
      @(negedge clk);
      check("abort_ack", {63'd0, jump_ack}, 64'd1);
      jump_req = 1'b0;
      @(negedge clk);
      home_req = 1'b1;
      @(negedge clk);
      home_req = 1'b0;
      check("abort_home", {60'd0, pos_mode_out}, 64'h1);
      saw_jump = 1'b0;
      for (int i = 0; i < C + D + 2; i++) begin
         @(negedge clk);
         if (pos_mode_out == 4'b0100 || jump_done) saw_jump = 1'b1;
      end
      check("abort_no_jump", {63'd0, saw_jump}, 64'd0);
      $display("[TB] abort sequence done");

      // Request held through COOLDOWN is re-accepted on the first CRUISE cycle.
      jump_req = 1'b1;
      for (int i = 1; i <= C + D + 6; i++) begin
         @(negedge clk);
         if (jump_ack) ack_idx.push_back(i);
      end
      jump_req = 1'b0;
      check("held_ack_count", 64'(ack_idx.size()), 64'd2);
      if (ack_idx.size() >= 2)
         check("held_ack_spacing", 64'(ack_idx[1] - ack_idx[0]), 64'(C + D + 2));
      $display("[TB] held request acks=%0d", ack_idx.size());

      // Asynchronous reset in the middle of the JUMP cycle.
      do_reset();
      jump_req = 1'b1; jump_target = 48'hABCD_0123_4567;
      @(negedge clk);
      jump_req = 1'b0;
      waited = 0;
      while (!jump_done && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("jump_reached", {63'd0, jump_done}, 64'd1);
      #2 rst = 1'b1;
      #1 check("async_reset_mid_jump", pack_out(),
               {5'd0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001, 48'd0});
      $display("[TB] async reset pm=%b jp=%h", pos_mode_out, jump_position_out);
      @(negedge clk);
      rst = 1'b0;

      // Randomized traffic against the reference model.
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      for (int n = 0; n < 800; n++) begin
         rst         = ($urandom_range(0, 99) == 0);
         cmd_mode    = $urandom_range(0, 1) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
         home_req    = ($urandom_range(0, 15) == 0);
         jump_req    = ($urandom_range(0, 2) == 0);
         jump_target = {$urandom, $urandom};
         @(posedge clk);
         model_step();
         @(negedge clk);
         check($sformatf("rand%0d", n), pack_out(), model_out());
         $display("[TB] rand %0d pm=%b mode=%b ack=%b done=%b busy=%b", n, pos_mode_out,
                  mode_out, jump_ack, jump_done, busy);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
